// File: rtl/x_ledser.sv
// x_ledser -- front-panel LED serializer.
//
// Snapshots the NLEDS-wide vector of flash-generator outputs and shifts it
// MSB-first into an external serial-in/parallel-out LED driver chain, then
// pulses the driver latch. Frames repeat on a refresh timer or on demand.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   leds        in   [NLEDS-1:0] LED states, 1 = LED on
//   force_req   in   request an immediate frame (level or pulse)
//   lamp_test   in   (only with LEDSER_LAMPTEST_EN) all-on capture + frame request
//   sclk        out  serial shift clock to the driver chain
//   sdat        out  serial data, stable H clocks either side of sclk rise
//   slat        out  driver latch strobe, active high
//   busy        out  frame in progress
//   frame_done  out  one-clock pulse on return to idle
//
// Optional feature macro: LEDSER_LAMPTEST_EN
//
// Parameters: NLEDS (2..64), SCKDIV (half-period H = 2**SCKDIV clocks),
// MXREF (refresh interval 2**MXREF clocks counted from frame load).

module x_ledser #(
  parameter int NLEDS  = 16,
  parameter int SCKDIV = 2,
  parameter int MXREF  = 17
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [NLEDS-1:0] leds,
  input  logic             force_req,
`ifdef LEDSER_LAMPTEST_EN
  input  logic             lamp_test,
`endif
  output logic             sclk,
  output logic             sdat,
  output logic             slat,
  output logic             busy,
  output logic             frame_done
);

  localparam int BW = (NLEDS > 1) ? $clog2(NLEDS) : 1;
  localparam int RW = MXREF + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHLO  = 3'd2,
    ST_SHHI  = 3'd3,
    ST_LATCH = 3'd4
  } state_t;

  state_t            state_r, state_nx_s;
  logic [SCKDIV-1:0] divcnt_r, div_nx_s;
  logic [BW-1:0]     bitcnt_r, bit_nx_s;
  logic [NLEDS-1:0]  sr_r, sr_nx_s;
  logic [RW-1:0]     rcnt_r, rcnt_nx_s;
  logic              pend_r, pend_nx_s;

  logic              sclk_nx_s, sdat_nx_s, slat_nx_s, busy_nx_s, done_nx_s;
  logic              tick_s, ref_done_s, set_req_s;
  logic [NLEDS-1:0]  cap_s;

  assign tick_s     = &divcnt_r;
  assign ref_done_s = rcnt_r[MXREF];

`ifdef LEDSER_LAMPTEST_EN
  logic lt_prev_r;

  // Previous lamp_test level, for rising-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lt_prev_r <= 1'b0;
    end else begin
      lt_prev_r <= lamp_test;
    end
  end

  assign set_req_s = force_req | (lamp_test & ~lt_prev_r);
  assign cap_s     = lamp_test ? {NLEDS{1'b1}} : leds;
`else
  assign set_req_s = force_req;
  assign cap_s     = leds;
`endif

  // Next-state, datapath and decoded-output logic.
  always_comb begin
    state_nx_s = ST_IDLE;
    div_nx_s   = divcnt_r + SCKDIV'(1);
    bit_nx_s   = bitcnt_r;
    sr_nx_s    = sr_r;

    case (state_r)
      ST_IDLE: begin
        div_nx_s = '0;
        // A saturated refresh counter starts the frame directly so the
        // interval is 2**MXREF counted clocks plus the single idle clock.
        if (pend_r || ref_done_s) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        sr_nx_s    = cap_s;
        div_nx_s   = '0;
        bit_nx_s   = '0;
        state_nx_s = ST_SHLO;
      end
      ST_SHLO: begin
        if (tick_s) begin
          state_nx_s = ST_SHHI;
        end else begin
          state_nx_s = ST_SHLO;
        end
      end
      ST_SHHI: begin
        if (tick_s) begin
          sr_nx_s  = {sr_r[NLEDS-2:0], 1'b0};
          bit_nx_s = bitcnt_r + BW'(1);
          if (bitcnt_r == BW'(NLEDS - 1)) begin
            state_nx_s = ST_LATCH;
          end else begin
            state_nx_s = ST_SHLO;
          end
        end else begin
          state_nx_s = ST_SHHI;
        end
      end
      ST_LATCH: begin
        if (tick_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_LATCH;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        div_nx_s   = '0;
        bit_nx_s   = '0;
      end
    endcase

    // Outputs are decoded from the next state so each pin moves on the
    // same edge as the state change it reflects.
    sclk_nx_s = 1'b0;
    sdat_nx_s = 1'b0;
    slat_nx_s = 1'b0;
    busy_nx_s = 1'b0;
    case (state_nx_s)
      ST_LOAD: begin
        busy_nx_s = 1'b1;
        sdat_nx_s = cap_s[NLEDS-1];
      end
      ST_SHLO: begin
        busy_nx_s = 1'b1;
        sdat_nx_s = sr_nx_s[NLEDS-1];
      end
      ST_SHHI: begin
        busy_nx_s = 1'b1;
        sclk_nx_s = 1'b1;
        sdat_nx_s = sr_nx_s[NLEDS-1];
      end
      ST_LATCH: begin
        busy_nx_s = 1'b1;
        slat_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
      end
    endcase
    done_nx_s = (state_r == ST_LATCH) && (state_nx_s == ST_IDLE);

    // A request arriving during load itself must survive into the next frame.
    if (state_r == ST_LOAD) begin
      pend_nx_s = set_req_s;
    end else begin
      pend_nx_s = pend_r | set_req_s | ref_done_s;
    end

    // Cleared on the load-entry edge; saturates instead of wrapping.
    if (state_nx_s == ST_LOAD) begin
      rcnt_nx_s = '0;
    end else if (ref_done_s) begin
      rcnt_nx_s = rcnt_r;
    end else begin
      rcnt_nx_s = rcnt_r + RW'(1);
    end
  end

  // State, datapath and registered-output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      divcnt_r   <= '0;
      bitcnt_r   <= '0;
      sr_r       <= '0;
      rcnt_r     <= '0;
      pend_r     <= 1'b1;
      sclk       <= 1'b0;
      sdat       <= 1'b0;
      slat       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      divcnt_r   <= div_nx_s;
      bitcnt_r   <= bit_nx_s;
      sr_r       <= sr_nx_s;
      rcnt_r     <= rcnt_nx_s;
      pend_r     <= pend_nx_s;
      sclk       <= sclk_nx_s;
      sdat       <= sdat_nx_s;
      slat       <= slat_nx_s;
      busy       <= busy_nx_s;
      frame_done <= done_nx_s;
    end
  end

endmodule

// File: tb/tb_x_ledser.sv
// Bench for x_ledser (NLEDS=16, SCKDIV=2, MXREF=10). A monitor reassembles
// each serial frame and compares it against expectations queued by the tests.

module tb_x_ledser;

  localparam int NL = 16;
  localparam int H  = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic [NL-1:0] leds = '0;
  logic          force_req = 1'b0;
`ifdef LEDSER_LAMPTEST_EN
  logic          lamp_test = 1'b0;
`endif
  logic          sclk, sdat, slat, busy, frame_done;

  x_ledser #(.NLEDS(NL), .SCKDIV(2), .MXREF(10)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .leds       (leds),
    .force_req  (force_req),
`ifdef LEDSER_LAMPTEST_EN
    .lamp_test  (lamp_test),
`endif
    .sclk       (sclk),
    .sdat       (sdat),
    .slat       (slat),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rel_cyc = 0;

  logic [NL-1:0] exp_q[$];

  // monitor state
  logic          sclk_p = 1'b0, slat_p = 1'b0, busy_p = 1'b0, sdat_p = 1'b0;
  logic          cur_bit = 1'b0;
  logic [NL-1:0] sh = '0;
  int nbits = 0, hi_cnt = 0, lat_cnt = 0, stab = 0;
  int idle_len = 0, idle_at_load = 0;
  int last_load_cyc = 0, loads = 0, done_cyc = 0, frames_done = 0;

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Frame monitor / scoreboard consumer, sampling on the falling edge.
  initial begin : monitor
    logic          fend;
    logic [NL-1:0] e;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        sclk_p = 1'b0; slat_p = 1'b0; busy_p = 1'b0; sdat_p = 1'b0;
        nbits = 0; hi_cnt = 0; lat_cnt = 0; stab = 0; idle_len = 0;
      end else begin
        if (sdat !== sdat_p) stab = 1; else stab = stab + 1;
        if (sclk && !sclk_p) begin
          sh = {sh[NL-2:0], sdat};
          nbits = nbits + 1;
          hi_cnt = 1;
          cur_bit = sdat;
          total++;
          if (stab < H + 1) begin
            bad++; $display("FAIL sdat_setup bit %0d: stable %0d clocks, need %0d", nbits, stab - 1, H);
          end
        end else if (sclk) begin
          hi_cnt = hi_cnt + 1;
          total++;
          if (sdat !== cur_bit) begin
            bad++; $display("FAIL sdat_hold: got %b want %b", sdat, cur_bit);
          end
        end
        if (!sclk && sclk_p) begin
          total++;
          if (hi_cnt != H) begin
            bad++; $display("FAIL sclk_high_len: got %0d want %0d", hi_cnt, H);
          end
        end
        if (slat && !slat_p) begin
          total++;
          if (nbits != NL || sclk !== 1'b0) begin
            bad++; $display("FAIL slat_start: bits=%0d sclk=%b want bits=%0d sclk=0", nbits, sclk, NL);
          end
        end
        if (slat) begin
          lat_cnt = lat_cnt + 1;
          total++;
          if (sdat !== 1'b0 || sclk !== 1'b0) begin
            bad++; $display("FAIL latch_pins: sdat=%b sclk=%b want 0 0", sdat, sclk);
          end
        end
        fend = slat_p && !slat;
        if (fend || frame_done) begin
          total++;
          if (frame_done !== fend) begin
            bad++; $display("FAIL frame_done_align: got %b want %b", frame_done, fend);
          end
        end
        if (fend) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++; $display("FAIL unexpected_frame: got %h want no frame", sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e || nbits != NL || lat_cnt != H) begin
              bad++;
              $display("FAIL frame_data: got %h bits=%0d lat=%0d want %h bits=%0d lat=%0d",
                       sh, nbits, lat_cnt, e, NL, H);
            end
          end
          done_cyc = cyc;
          frames_done = frames_done + 1;
          nbits = 0;
          lat_cnt = 0;
        end
        if (busy && !busy_p) begin
          idle_at_load = idle_len;
          idle_len = 0;
          last_load_cyc = cyc;
          loads = loads + 1;
        end else if (!busy) begin
          idle_len = idle_len + 1;
        end
        sclk_p = sclk; slat_p = slat; busy_p = busy; sdat_p = sdat;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic hold_reset(input logic [NL-1:0] v);
    reset_n   = 1'b0;
    force_req = 1'b0;
    leds      = v;
    repeat (3) @(negedge clock);
    #2;
  endtask

  task automatic release_reset(input logic [NL-1:0] v);
    exp_q.push_back(v);
    reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic wait_frame(input int budget);
    int tgt;
    tgt = frames_done + 1;
    for (int i = 0; i < budget && frames_done < tgt; i++) begin
      @(negedge clock);
      #1;
    end
    total++;
    if (frames_done < tgt) begin
      bad++; $display("FAIL frame_timeout: frames=%0d want %0d", frames_done, tgt);
    end
  endtask

  task automatic test_reset;
    hold_reset(16'hA5C3);
    total++;
    if ({sclk, sdat, slat, busy, frame_done} !== 5'b00000) begin
      bad++; $display("FAIL reset_outputs: got %b want 00000", {sclk, sdat, slat, busy, frame_done});
    end
    release_reset(16'hA5C3);
    wait_frame(300);
    total++;
    if (last_load_cyc - rel_cyc != 1) begin
      bad++; $display("FAIL reset_load_delay: got %0d want 1", last_load_cyc - rel_cyc);
    end
    total++;
    if (done_cyc - rel_cyc != 134) begin
      bad++; $display("FAIL frame_done_clock: got %0d want 134", done_cyc - rel_cyc);
    end
  endtask

  task automatic test_snapshot;
    hold_reset(16'hA5C3);
    release_reset(16'hA5C3);
    repeat (60) @(negedge clock);
    #1;
    leds = 16'h0001;
    wait_frame(300);
    exp_q.push_back(16'h0001);
    force_req = 1'b1;
    @(negedge clock);
    #1;
    force_req = 1'b0;
    wait_frame(300);
  endtask

  task automatic test_back_to_back;
    int d1;
    hold_reset(16'h3C5A);
    release_reset(16'h3C5A);
    for (int i = 0; i < 200 && !(nbits == 6 && sclk); i++) begin
      @(negedge clock);
      #1;
    end
    total++;
    if (!(nbits == 6 && sclk === 1'b1)) begin
      bad++; $display("FAIL reach_bit5_high: bits=%0d sclk=%b want 6 1", nbits, sclk);
    end
    exp_q.push_back(16'h3C5A);
    force_req = 1'b1;
    @(negedge clock);
    #1;
    force_req = 1'b0;
    wait_frame(300);
    d1 = done_cyc;
    wait_frame(300);
    total++;
    if (last_load_cyc - d1 != 1) begin
      bad++; $display("FAIL force_reload_gap: got %0d want 1", last_load_cyc - d1);
    end
    total++;
    if (idle_at_load != 1) begin
      bad++; $display("FAIL busy_low_len: got %0d want 1", idle_at_load);
    end
  endtask

  task automatic test_refresh;
    int l1, l2, n;
    hold_reset(16'h8001);
    release_reset(16'h8001);
    wait_frame(300);
    l1 = last_load_cyc;
    leds = 16'h7FFE;
    exp_q.push_back(16'h7FFE);
    wait_frame(1200);
    l2 = last_load_cyc;
    total++;
    if (l2 - l1 != 1025) begin
      bad++; $display("FAIL refresh_interval1: got %0d want 1025", l2 - l1);
    end
    // force coincident with the first ref_done cycle must yield one frame
    leds = 16'h0F0F;
    exp_q.push_back(16'h0F0F);
    for (int i = 0; i < 1200 && cyc < l2 + 1024; i++) begin
      @(negedge clock);
      #1;
    end
    force_req = 1'b1;
    @(negedge clock);
    #1;
    force_req = 1'b0;
    wait_frame(300);
    total++;
    if (last_load_cyc - l2 != 1025) begin
      bad++; $display("FAIL refresh_interval2: got %0d want 1025", last_load_cyc - l2);
    end
    n = loads;
    repeat (300) @(negedge clock);
    #1;
    total++;
    if (loads != n) begin
      bad++; $display("FAIL single_frame: got %0d loads want %0d", loads, n);
    end
  endtask

  task automatic test_reset_midframe;
    hold_reset(16'hA5C3);
    release_reset(16'hA5C3);
    for (int i = 0; i < 200 && nbits != 10; i++) begin
      @(negedge clock);
      #1;
    end
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({sclk, sdat, slat, busy} !== 4'b0000) begin
      bad++; $display("FAIL async_reset_pins: got %b want 0000", {sclk, sdat, slat, busy});
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    hold_reset(16'hA5C3);
    release_reset(16'hA5C3);
    wait_frame(300);
    total++;
    if (last_load_cyc - rel_cyc != 1) begin
      bad++; $display("FAIL restart_delay: got %0d want 1", last_load_cyc - rel_cyc);
    end
  endtask

`ifdef LEDSER_LAMPTEST_EN
  task automatic test_lamp;
    hold_reset(16'h0000);
    lamp_test = 1'b0;
    release_reset(16'h0000);
    wait_frame(300);
    exp_q.push_back(16'hFFFF);
    lamp_test = 1'b1;
    wait_frame(300);
    lamp_test = 1'b0;
    exp_q.push_back(16'h0000);
    wait_frame(1200);
  endtask
`endif

  initial begin : main
    #1;
    test_reset;
    test_snapshot;
    test_back_to_back;
    test_refresh;
    test_reset_midframe;
`ifdef LEDSER_LAMPTEST_EN
    test_lamp;
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL leftover_expect: got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/x_ledser.md
Name: x_ledser

Overview:
Front-panel LED serializer that sits directly downstream of the per-LED flash pulse generators. It snapshots the NLEDS-wide vector of flash outputs and shifts it MSB-first into an external serial-in/parallel-out LED driver chain. A latch strobe updates the driver outputs after each frame. Frames repeat on a refresh timer, or on demand via a force input.

Parameters:
NLEDS, 16, number of LED bits per frame (2..64)
SCKDIV, 2, serial half-period H = 2**SCKDIV clocks (SCKDIV >= 1)
MXREF, 17, refresh counter MSB index; refresh interval = 2**MXREF clocks counted from frame load

Ports:
clock  in  1  system clock (40 MHz)
reset_n  in  1  asynchronous active-low reset
leds  in  NLEDS  LED states from the flash generators; 1 = LED on
force  in  1  request an immediate frame; level or pulse, sampled every clock
sclk  out  1  serial shift clock to the LED driver chain
sdat  out  1  serial data, valid across the sclk rising edge
slat  out  1  driver latch strobe, active high
busy  out  1  frame in progress
frame_done  out  1  one-clock pulse when a frame completes

Behaviour:
- Clock and reset: one clock. reset_n is asynchronous and active-low. Everything else is synchronous to clock.
- Reset values: sclk=0, sdat=0, slat=0, busy=0, frame_done=0, state=idle, rcnt=0, divcnt=0, bitcnt=0, pend=1. The pending frame guarantees a frame right after reset.
- Output timing: every output is a flop decoded from the next state. Each output changes on the same clock edge as the state change it reflects, so pins never glitch.
- Refresh counter rcnt is MXREF+1 bits wide:
  - clears in load;
  - otherwise increments and saturates at bit MXREF set;
  - ref_done = rcnt[MXREF].
- Pending flag pend:
  - set by force in any state, or by ref_done;
  - cleared in load unless force is high in that same cycle; in that case pend stays 1.
- States:
  - idle: sclk=0, slat=0, busy=0. If pend, go to load on the next clock.
  - load (1 clock):
    - shift register sr <= leds (lamp-test masked, see the optional feature);
    - bitcnt=0, divcnt=0;
    - busy=1, sdat=leds[NLEDS-1];
    - go to shlo.
  - shlo: sclk=0, sdat=sr[NLEDS-1]. divcnt counts; on tick (divcnt all ones) go to shhi.
  - shhi: sclk=1, sdat held. On tick:
    - sr shifts left 1, bitcnt++;
    - if bitcnt was NLEDS-1, go to latch; else go to shlo.
  - latch: sclk=0, sdat=0, slat=1 for H clocks. On tick go to idle; frame_done=1 for exactly one clock, aligned with the idle entry.
  - Any undefined state encoding goes to idle on the next clock (safe state machine).
- Data timing: sdat is stable for H clocks before and H clocks after each sclk rising edge.
- Snapshot rule: leds is sampled only in load. Changes during a frame appear in the next frame.
- Frame length: 1 + 2*NLEDS*H + H clocks from load entry to idle entry. Defaults give 133 clocks.
- Boundary conditions:
  - force during a frame sets pend; the next load follows after exactly 1 idle clock.
  - force and ref_done together produce a single frame.
  - Reset mid-frame: all outputs go low asynchronously. A fresh frame starts 1 clock after reset release (idle then load).
  - rcnt saturates and never wraps.

Optional Feature:
- Macro: LEDSER_LAMPTEST_EN.
- When defined:
  - adds port lamp_test (in, 1);
  - while lamp_test=1, load captures all ones instead of leds;
  - a rising edge of lamp_test sets pend, the same as force.
- When undefined: the port is absent and load always captures leds.

Test Plan:
1. Reset release with leds=16'hA5C3 and defaults -> load 1 clock after release. sdat sampled on 16 sclk rising edges reads 1010_0101_1100_0011. Each sclk high lasts 4 clocks. slat high for 4 clocks after the 16th sclk fall. frame_done pulses at clock 134.
2. leds changes to 16'h0001 at mid-frame -> the current frame still shifts A5C3. A force pulse then produces a frame shifting 0000_0000_0000_0001.
3. force held 1 clock during shhi of bit 5 -> after frame_done, 1 idle clock, then a new load. busy is low for exactly 1 clock.
4. MXREF=10 with no force -> successive loads occur exactly 1025 clocks apart (1024 counted plus 1 idle).
5. reset_n low during bit 9 -> sclk, sdat, slat and busy go to 0 immediately. After release a complete 16-bit frame follows with no partial bits.
6. LEDSER_LAMPTEST_EN defined, leds=0, lamp_test rises -> next frame shifts 16 ones. After lamp_test falls, the following refresh frame shifts 0.
